imem_dmem_arbiter: RTL and testbench

- Shares one single-port unified memory between the fetch stage (instruction requester) and the memory stage (data requester) of the 5-stage pipeline.
- Sequences one memory transaction at a time and returns read data and ready pulses.
- Produces stall requests that the pipeline control ORs into StallF/StallD/StallE/StallM.
- Handles fetch kills on taken-branch redirect (PCSrcE) and memory timeouts.

---
 rtl/imem_dmem_arbiter.sv | 82 ++++++++
 tb/tb_imem_dmem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port memory between fetch and data requesters,
// one transaction at a time, with fetch-starvation protection, kill and timeout handling.
module imem_dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 16,
    parameter int STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_kill,
    output logic          i_ready,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          bus_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          stall_f,
    output logic          stall_m
);
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
    localparam logic [7:0] waitLast = 8'(TIMEOUT - 1);
    localparam logic [3:0] starveMax = 4'(STARVE_LIMIT);
    state_t state, nextState;
    logic [7:0] waitCnt;
    logic [3:0] starveCnt;
    logic killed;
    logic fetchOk, forceFetch, grantI, grantD, busy, done, iDone, dDone;
    always_comb begin
        fetchOk = i_req && !i_kill;
        forceFetch = fetchOk && starveCnt == starveMax;
        grantI = state == IDLE && fetchOk && (forceFetch || !d_req);
        grantD = state == IDLE && d_req && !forceFetch;
        busy = state != IDLE;
        done = busy && (mem_valid || waitCnt == waitLast);
        // a kill seen on the completion cycle itself also swallows the response
        iDone = state == I_BUSY && done && !killed && !i_kill;
        dDone = state == D_BUSY && done;
        nextState = grantI ? I_BUSY : grantD ? D_BUSY : done ? IDLE : state;
    end
    // every output is forced low while reset_n is asserted
    always_comb begin
        mem_en = reset_n && (grantI || grantD);
        mem_we = reset_n && grantD && d_we;
        mem_addr = !reset_n ? '0 : grantD ? d_addr : grantI ? i_addr : '0;
        mem_wdata = (reset_n && grantD) ? d_wdata : '0;
        i_ready = reset_n && iDone;
        d_ready = reset_n && dDone;
        i_rdata = (i_ready && mem_valid) ? mem_rdata : '0;
        d_rdata = (d_ready && mem_valid) ? mem_rdata : '0;
        bus_err = (i_ready || d_ready) && !mem_valid;
        stall_f = reset_n && i_req && !i_ready;
        stall_m = reset_n && d_req && !d_ready;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            waitCnt <= '0;
            starveCnt <= '0;
            killed <= 1'b0;
        end else begin
            state <= nextState;
            waitCnt <= (busy && !done) ? waitCnt + 8'd1 : '0;
            killed <= state == I_BUSY && !done && (killed || i_kill);
            if (grantI)
                starveCnt <= '0;
            else if (grantD && fetchOk && starveCnt != starveMax)
                starveCnt <= starveCnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: per-cycle directed vectors for the arbiter (TIMEOUT=4, STARVE_LIMIT=3)
// plus a hand-written asynchronous reset sequence.
module tb_imem_dmem_arbiter;
    logic clk = 1'b0, reset_n = 1'b0;
    logic i_req, i_kill, i_ready, d_req, d_we, d_ready, bus_err;
    logic mem_en, mem_we, mem_valid, stall_f, stall_m;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    imem_dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .bus_err(bus_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic iReq, iKill;
        logic [31:0] iAddr;
        logic dReq, dWe;
        logic [31:0] dAddr, dWdata;
        logic memValid;
        logic [31:0] memRdata;
    } ins_t;

    typedef struct packed {
        logic iReady;
        logic [31:0] iRdata;
        logic dReady;
        logic [31:0] dRdata;
        logic busErr, memEn, memWe;
        logic [31:0] memAddr, memWdata;
        logic stallF, stallM;
    } outs_t;

    typedef struct packed {
        ins_t stim;
        outs_t exp;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;

    // stall expectations follow directly from the stall definitions: request present, ready absent
    function automatic vec_t mk(input logic [31:0] iReq, iKill, iAddr, dReq, dWe, dAddr, dWdata, mV, mR,
                                eIR, eIRd, eDR, eDRd, eBE, eEn, eWe, eAddr, eWd);
        vec_t v;
        v.stim = '{iReq[0], iKill[0], iAddr, dReq[0], dWe[0], dAddr, dWdata, mV[0], mR};
        v.exp = '{eIR[0], eIRd, eDR[0], eDRd, eBE[0], eEn[0], eWe[0], eAddr, eWd,
                  iReq[0] & ~eIR[0], dReq[0] & ~eDR[0]};
        return v;
    endfunction

    task automatic drive(input ins_t s);
        i_req = s.iReq; i_kill = s.iKill; i_addr = s.iAddr;
        d_req = s.dReq; d_we = s.dWe; d_addr = s.dAddr; d_wdata = s.dWdata;
        mem_valid = s.memValid; mem_rdata = s.memRdata;
    endtask

    task automatic check(input string name, input outs_t exp);
        outs_t a;
        a = '{i_ready, i_rdata, d_ready, d_rdata, bus_err, mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m};
        checks++;
        if (a !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, a, exp);
        end
    endtask

    initial begin
        vec_t v;
        // reset state after release
        vecs.push_back(mk(0,0,0,      0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        // fetch alone, latency 1, back-to-back fetches
        vecs.push_back(mk(1,0,'h100,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h100,0));
        vecs.push_back(mk(1,0,'h100,  0,0,0,0,             1,'h00500093,  1,'h00500093,0,0,0,    0,0,0,0));
        vecs.push_back(mk(1,0,'h104,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h104,0));
        vecs.push_back(mk(1,0,'h104,  0,0,0,0,             1,'h00a00113,  1,'h00a00113,0,0,0,    0,0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        // fetch and load together, latency 2: data first, fetch issues right after d_ready
        vecs.push_back(mk(1,0,'h108,  1,0,'h2000,'h55,     0,0,           0,0,0,0,0,             1,0,'h2000,'h55));
        vecs.push_back(mk(1,0,'h108,  1,0,'h2000,'h55,     0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h108,  1,0,'h2000,'h55,     1,'h12345678,  0,0,1,'h12345678,0,    0,0,0,0));
        vecs.push_back(mk(1,0,'h108,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h108,0));
        vecs.push_back(mk(1,0,'h108,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h108,  0,0,0,0,             1,'h11111111,  1,'h11111111,0,0,0,    0,0,0,0));
        // starvation: three loads win, fourth arbitration goes to fetch, then data wins again
        vecs.push_back(mk(1,0,'h200,  1,0,'h3000,0,        0,0,           0,0,0,0,0,             1,0,'h3000,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h3000,0,        1,'ha1,        0,0,1,'ha1,0,          0,0,0,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h3004,0,        0,0,           0,0,0,0,0,             1,0,'h3004,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h3004,0,        1,'ha2,        0,0,1,'ha2,0,          0,0,0,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h3008,0,        0,0,           0,0,0,0,0,             1,0,'h3008,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h3008,0,        1,'ha3,        0,0,1,'ha3,0,          0,0,0,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h300c,0,        0,0,           0,0,0,0,0,             1,0,'h200,0));
        vecs.push_back(mk(1,0,'h200,  1,0,'h300c,0,        1,'hf00d,      1,'hf00d,0,0,0,        0,0,0,0));
        vecs.push_back(mk(1,0,'h204,  1,0,'h300c,0,        0,0,           0,0,0,0,0,             1,0,'h300c,0));
        vecs.push_back(mk(1,0,'h204,  1,0,'h300c,0,        1,'ha4,        0,0,1,'ha4,0,          0,0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        // kill in I_BUSY, kill in IDLE, kill on the completion cycle, late mem_valid in IDLE
        vecs.push_back(mk(1,0,'h300,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h300,0));
        vecs.push_back(mk(1,1,'h300,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h400,  0,0,0,0,             1,'hdeadbeef,  0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h400,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h400,0));
        vecs.push_back(mk(1,0,'h400,  0,0,0,0,             1,'h13,        1,'h13,0,0,0,          0,0,0,0));
        vecs.push_back(mk(1,1,'h404,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h500,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h500,0));
        vecs.push_back(mk(1,1,'h500,  0,0,0,0,             1,'hbad,       0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,0,             1,'h77,        0,0,0,0,0,             0,0,0,0));
        // store timeout on the 4th cycle after issue, then a late response is ignored
        vecs.push_back(mk(0,0,0,      1,1,'h4000,'hcafef00d, 0,0,         0,0,0,0,0,             1,1,'h4000,'hcafef00d));
        vecs.push_back(mk(0,0,0,      1,1,'h4000,'hcafef00d, 0,0,         0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,1,'h4000,'hcafef00d, 0,0,         0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,1,'h4000,'hcafef00d, 0,0,         0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,1,'h4000,'hcafef00d, 0,0,         0,0,1,0,1,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,0,             1,'h99,        0,0,0,0,0,             0,0,0,0));
        // mem_valid arriving exactly at the timeout cycle completes normally
        vecs.push_back(mk(0,0,0,      1,0,'h4004,0,        0,0,           0,0,0,0,0,             1,0,'h4004,0));
        vecs.push_back(mk(0,0,0,      1,0,'h4004,0,        0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,0,'h4004,0,        0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,0,'h4004,0,        0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      1,0,'h4004,0,        1,'h77,        0,0,1,'h77,0,          0,0,0,0));
        // fetch timeout raises i_ready with bus_err and zero data
        vecs.push_back(mk(1,0,'h600,  0,0,0,0,             0,0,           0,0,0,0,0,             1,0,'h600,0));
        vecs.push_back(mk(1,0,'h600,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h600,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h600,  0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));
        vecs.push_back(mk(1,0,'h600,  0,0,0,0,             0,0,           1,0,0,0,1,             0,0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,0,             0,0,           0,0,0,0,0,             0,0,0,0));

        // outputs must read zero while reset is held, even with all requests active
        v = mk(1,0,'h100, 1,1,'h2000,'h1234, 1,'hffffffff, 0,0,0,0,0, 0,0,0,0);
        drive(v.stim);
        #1 check("reset_hold", '0);
        @(negedge clk);
        #1 check("reset_hold_clk", '0);
        drive(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0,0).stim);
        @(negedge clk) reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].stim);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // asynchronous reset in the middle of a load, then a clean re-issue
        @(negedge clk);
        v = mk(1,0,'h700, 1,0,'h5000,0, 0,0, 0,0,0,0,0, 1,0,'h5000,0);
        drive(v.stim);
        #1 check("rst_issue", v.exp);
        @(negedge clk);
        v = mk(1,0,'h700, 1,0,'h5000,0, 0,0, 0,0,0,0,0, 0,0,0,0);
        drive(v.stim);
        #1 check("rst_busy", v.exp);
        #2 reset_n = 1'b0;
        #1 check("rst_async_zero", '0);
        @(negedge clk) reset_n = 1'b1;
        v = mk(1,0,'h700, 1,0,'h5000,0, 0,0, 0,0,0,0,0, 1,0,'h5000,0);
        #1 check("rst_reissue", v.exp);
        @(negedge clk);
        v = mk(1,0,'h700, 1,0,'h5000,0, 1,'h5a5a, 0,0,1,'h5a5a,0, 0,0,0,0);
        drive(v.stim);
        #1 check("rst_complete", v.exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
